ex_result_buffer: RTL

Execute-to-memory result buffer for the 64-bit RISC-V pipeline. It captures the combined ALU result (XOR, AND, OR, add and the other execute units) together with the destination-register tag. It presents the result to the MEM stage through a valid/ready handshake. A two-entry skid structure lets the execute stage run at full rate while the downstream ready signal stays fully registered, with no combinational path from out_ready to in_ready.

---
 rtl/ex_result_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/ex_result_buffer.sv
// Execute-to-memory result buffer: main (head) register plus a skid register, valid/ready on both sides.
// in_ready is decoded from registered state only, so out_ready never reaches in_ready combinationally.
module ex_result_buffer #(
  parameter int WIDTH = 64,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_reg_write,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_result, skid_result;
  logic [RD_W-1:0]  main_rd, skid_rd;
  logic             main_we, skid_we;
  logic             main_zero, skid_zero;

  logic push, pop, in_we, in_zero;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Writes to x0 are dropped here so writeback never sees them; rd itself is kept.
  assign in_we     = in_reg_write & (in_rd != '0);
  assign in_zero   = (in_result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_result <= '0;
      main_rd     <= '0;
      main_we     <= 1'b0;
      main_zero   <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_we     <= 1'b0;
      skid_zero   <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state       <= ONE;
            main_result <= in_result;
            main_rd     <= in_rd;
            main_we     <= in_we;
            main_zero   <= in_zero;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_result <= in_result;
            main_rd     <= in_rd;
            main_we     <= in_we;
            main_zero   <= in_zero;
          end else if (push) begin
            state       <= FULL;
            skid_result <= in_result;
            skid_rd     <= in_rd;
            skid_we     <= in_we;
            skid_zero   <= in_zero;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state       <= ONE;
            main_result <= skid_result;
            main_rd     <= skid_rd;
            main_we     <= skid_we;
            main_zero   <= skid_zero;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_result    = main_result;
  assign out_rd        = main_rd;
  // Gated so stale head contents after a pop or flush never look like a write.
  assign out_reg_write = main_we & out_valid;
  assign out_zero      = main_zero;

endmodule
